// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the LEGv8 pipeline control slice: opcode patterns,
// control enums and the per-stage control structs carried down the pipe.
package pipe_ctrl_pkg;

    localparam int OP_BITS  = 11;
    localparam int LINK_REG = 30;

    // Opcode value/care-mask pairs; mask bits at 0 are don't-care.
    localparam logic [10:0] B_VAL     = 11'b00010100000, B_MASK     = 11'b11111100000;
    localparam logic [10:0] BCOND_VAL = 11'b01010100000, BCOND_MASK = 11'b11111111000;
    localparam logic [10:0] CBZ_VAL   = 11'b10110100000, CBZ_MASK   = 11'b11111111000;
    localparam logic [10:0] BL_VAL    = 11'b10010100000, BL_MASK    = 11'b11111100000;
    localparam logic [10:0] BR_VAL    = 11'b11010110000, BR_MASK    = 11'b11111111111;
    localparam logic [10:0] ADDI_VAL  = 11'b10010001000, ADDI_MASK  = 11'b11111111110;
    localparam logic [10:0] ADDS_VAL  = 11'b10101011000, ADDS_MASK  = 11'b11111111111;
    localparam logic [10:0] SUBS_VAL  = 11'b11101011000, SUBS_MASK  = 11'b11111111111;
    localparam logic [10:0] LDUR_VAL  = 11'b11111000010, LDUR_MASK  = 11'b11111111111;
    localparam logic [10:0] STUR_VAL  = 11'b11111000000, STUR_MASK  = 11'b11111111111;

    localparam logic [1:0] SRC_REG  = 2'b00;
    localparam logic [1:0] SRC_DOFF = 2'b01;
    localparam logic [1:0] SRC_IMM  = 2'b10;

    typedef enum logic [3:0] {
        OP_NOP, OP_B, OP_BCOND, OP_CBZ, OP_BL, OP_BR,
        OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR, OP_STUR
    } op_e;

    typedef enum logic [2:0] {
        PASS_B = 3'b000,
        ADD    = 3'b010,
        SUB    = 3'b011
    } aluop_e;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_HS, COND_LO, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_ALX
    } cond_e;

    typedef struct packed {
        logic       valid;
        logic       set_flags;
        aluop_e     aluop;
        logic [1:0] alusrc;
    } ex_ctrl_t;

    typedef struct packed {
        logic valid;
        logic write;
        logic read;
    } mem_ctrl_t;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memtoreg;
        logic bl;
    } wb_ctrl_t;

    function automatic logic op_match(logic [10:0] op, logic [10:0] val, logic [10:0] mask);
        return ((op ^ val) & mask) == 11'd0;
    endfunction

    function automatic op_e classify(logic [10:0] op);
        if      (op_match(op, B_VAL,     B_MASK))     return OP_B;
        else if (op_match(op, BCOND_VAL, BCOND_MASK)) return OP_BCOND;
        else if (op_match(op, CBZ_VAL,   CBZ_MASK))   return OP_CBZ;
        else if (op_match(op, BL_VAL,    BL_MASK))    return OP_BL;
        else if (op_match(op, BR_VAL,    BR_MASK))    return OP_BR;
        else if (op_match(op, ADDI_VAL,  ADDI_MASK))  return OP_ADDI;
        else if (op_match(op, ADDS_VAL,  ADDS_MASK))  return OP_ADDS;
        else if (op_match(op, SUBS_VAL,  SUBS_MASK))  return OP_SUBS;
        else if (op_match(op, LDUR_VAL,  LDUR_MASK))  return OP_LDUR;
        else if (op_match(op, STUR_VAL,  STUR_MASK))  return OP_STUR;
        else                                          return OP_NOP;
    endfunction

endpackage

// File: rtl/pipe_control_cond_eval.sv
// Combinational B.cond evaluator over NZCV using the ARM condition encoding.
// With full_cond low only LT can ever be taken.
module cond_eval
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    input  logic       full_cond,
    output logic       taken
);

    logic n, z, c, v;
    logic result;

    assign n = nzcv[3];
    assign z = nzcv[2];
    assign c = nzcv[1];
    assign v = nzcv[0];

    always_comb begin
        result = 1'b0;
        case (cond)
            COND_EQ:  result = z;
            COND_NE:  result = !z;
            COND_HS:  result = c;
            COND_LO:  result = !c;
            COND_MI:  result = n;
            COND_PL:  result = !n;
            COND_VS:  result = v;
            COND_VC:  result = !v;
            COND_HI:  result = c && !z;
            COND_LS:  result = !(c && !z);
            COND_GE:  result = (n == v);
            COND_LT:  result = (n != v);
            COND_GT:  result = !z && (n == v);
            COND_LE:  result = z || (n != v);
            COND_AL:  result = 1'b1;
            COND_ALX: result = 1'b1;
            default:  result = 1'b0;
        endcase
    end

    assign taken = full_cond ? result : ((cond == COND_LT) && (n != v));

endmodule

// File: rtl/pipe_control.sv
// LEGv8 5-stage pipeline control: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// pipes, NZCV register, branch resolution and load-use / branch-operand stalls.
module pipe_control
    import pipe_ctrl_pkg::*;
#(
    parameter int OPW         = 11,
    parameter int RAW         = 5,
    parameter int FULL_COND   = 1,
    parameter int FLAG_BYPASS = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           id_valid,
    input  logic [OPW-1:0] id_opcode,
    input  logic [3:0]     id_cond,
    input  logic [RAW-1:0] id_rn,
    input  logic [RAW-1:0] id_rm,
    input  logic [RAW-1:0] id_rd,
    input  logic           cbz_zero,
    input  logic [3:0]     ex_flags_in,
    output logic           stall,
    output logic           flush_if,
    output logic           id_reg2loc,
    output logic           id_br_taken,
    output logic           id_uncond_br,
    output logic           id_br_reg,
    output logic           ex_valid,
    output logic           ex_set_flags,
    output logic [2:0]     ex_aluop,
    output logic [1:0]     ex_alusrc,
    output logic           mem_valid,
    output logic           mem_write,
    output logic           mem_read,
    output logic           wb_valid,
    output logic           wb_regwrite,
    output logic           wb_memtoreg,
    output logic           wb_bl,
    output logic [RAW-1:0] wb_rd,
    output logic [3:0]     flags_q
);

    localparam logic [RAW-1:0] XZR = '1;

    logic [10:0]    op;
    op_e            op_kind;
    ex_ctrl_t       dec_ex;
    mem_ctrl_t      dec_mem;
    wb_ctrl_t       dec_wb;
    logic [RAW-1:0] dec_rd;
    logic           reg2loc, uncond, br_reg, raw_taken;
    logic           lu_rn, lu_src2, br_chk;
    logic           cond_taken, load_use, br_hazard, go;
    logic [RAW-1:0] src2, br_src;
    logic [3:0]     flags_src;

    ex_ctrl_t       idex_ex;
    mem_ctrl_t      idex_mem, exmem_mem;
    wb_ctrl_t       idex_wb, exmem_wb, memwb_wb;
    logic [RAW-1:0] idex_rd, exmem_rd, memwb_rd;

    assign op      = id_opcode[OPW-1 -: OP_BITS];
    assign op_kind = classify(op);

    // Same-cycle bypass lets a B.cond right behind ADDS/SUBS see the new flags.
    assign flags_src = ((FLAG_BYPASS != 0) && idex_ex.valid && idex_ex.set_flags)
                       ? ex_flags_in : flags_q;

    cond_eval u_cond_eval (
        .cond      (id_cond),
        .nzcv      (flags_src),
        .full_cond (FULL_COND != 0),
        .taken     (cond_taken)
    );

    always_comb begin
        dec_ex    = '0;
        dec_mem   = '0;
        dec_wb    = '0;
        dec_rd    = '0;
        reg2loc   = 1'b0;
        uncond    = 1'b0;
        br_reg    = 1'b0;
        raw_taken = 1'b0;
        lu_rn     = 1'b0;
        lu_src2   = 1'b0;
        br_chk    = 1'b0;
        dec_ex.aluop  = PASS_B;
        dec_ex.alusrc = SRC_REG;
        case (op_kind)
            OP_B: begin
                uncond = 1'b1; raw_taken = 1'b1;
            end
            OP_BCOND: raw_taken = cond_taken;
            OP_CBZ: begin
                reg2loc = 1'b1; br_chk = 1'b1; raw_taken = cbz_zero;
            end
            OP_BL: begin
                uncond = 1'b1; raw_taken = 1'b1;
                dec_wb.regwrite = 1'b1; dec_wb.bl = 1'b1;
                dec_rd = RAW'(LINK_REG);
            end
            OP_BR: begin
                uncond = 1'b1; br_reg = 1'b1; raw_taken = 1'b1; br_chk = 1'b1;
            end
            OP_ADDI: begin
                dec_ex.aluop = ADD; dec_ex.alusrc = SRC_IMM;
                dec_wb.regwrite = 1'b1; dec_rd = id_rd; lu_rn = 1'b1;
            end
            OP_ADDS, OP_SUBS: begin
                dec_ex.aluop = (op_kind == OP_SUBS) ? SUB : ADD;
                dec_ex.set_flags = 1'b1;
                dec_wb.regwrite = 1'b1; dec_rd = id_rd;
                lu_rn = 1'b1; lu_src2 = 1'b1;
            end
            OP_LDUR: begin
                dec_ex.aluop = ADD; dec_ex.alusrc = SRC_DOFF;
                dec_mem.read = 1'b1;
                dec_wb.regwrite = 1'b1; dec_wb.memtoreg = 1'b1; dec_rd = id_rd;
            end
            OP_STUR: begin
                dec_ex.aluop = ADD; dec_ex.alusrc = SRC_DOFF;
                dec_mem.write = 1'b1; reg2loc = 1'b1;
                lu_rn = 1'b1; lu_src2 = 1'b1;
            end
            default: ;
        endcase
        dec_ex.valid  = (op_kind != OP_NOP);
        dec_mem.valid = (op_kind != OP_NOP);
        dec_wb.valid  = (op_kind != OP_NOP);
    end

    // Branches resolve in ID, so their source must wait out an ALU result in
    // EX or a load still in MEM; ALU consumers only wait on a load in EX.
    always_comb begin
        src2   = reg2loc ? id_rd : id_rm;
        br_src = (op_kind == OP_CBZ) ? id_rd : id_rn;
        load_use = id_valid && idex_ex.valid && idex_mem.read && (idex_rd != XZR) &&
                   ((lu_rn && (idex_rd == id_rn)) || (lu_src2 && (idex_rd == src2)));
        br_hazard = id_valid && br_chk &&
                    ((idex_ex.valid && idex_wb.regwrite && (idex_rd != XZR) && (idex_rd == br_src)) ||
                     (exmem_mem.valid && exmem_mem.read && (exmem_rd != XZR) && (exmem_rd == br_src)));
    end

    assign stall        = load_use || br_hazard;
    assign go           = id_valid && !stall;
    assign id_br_taken  = go && raw_taken;
    assign flush_if     = id_br_taken;
    assign id_reg2loc   = go && reg2loc;
    assign id_uncond_br = go && uncond;
    assign id_br_reg    = go && br_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idex_ex   <= '0;
            idex_mem  <= '0;
            idex_wb   <= '0;
            idex_rd   <= '0;
            exmem_mem <= '0;
            exmem_wb  <= '0;
            exmem_rd  <= '0;
            memwb_wb  <= '0;
            memwb_rd  <= '0;
            flags_q   <= 4'b0000;
        end else begin
            if (go) begin
                idex_ex  <= dec_ex;
                idex_mem <= dec_mem;
                idex_wb  <= dec_wb;
                idex_rd  <= dec_rd;
            end else begin
                idex_ex  <= '0;
                idex_mem <= '0;
                idex_wb  <= '0;
                idex_rd  <= '0;
            end
            exmem_mem <= idex_mem;
            exmem_wb  <= idex_wb;
            exmem_rd  <= idex_rd;
            memwb_wb  <= exmem_wb;
            memwb_rd  <= exmem_rd;
            if (idex_ex.valid && idex_ex.set_flags)
                flags_q <= ex_flags_in;
        end
    end

    assign ex_valid     = idex_ex.valid;
    assign ex_set_flags = idex_ex.set_flags;
    assign ex_aluop     = idex_ex.aluop;
    assign ex_alusrc    = idex_ex.alusrc;
    assign mem_valid    = exmem_mem.valid;
    assign mem_write    = exmem_mem.write;
    assign mem_read     = exmem_mem.read;
    assign wb_valid     = memwb_wb.valid;
    assign wb_regwrite  = memwb_wb.regwrite;
    assign wb_memtoreg  = memwb_wb.memtoreg;
    assign wb_bl        = memwb_wb.bl;
    assign wb_rd        = memwb_rd;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed pipeline scenarios then randomized streams,
// checked against an instruction-level model of the pipe.
module tb_pipe_control;

    localparam int RAW = 5;
    localparam int XZR = 31;
    localparam int K_NOP = 0, K_B = 1, K_BCOND = 2, K_CBZ = 3, K_BL = 4, K_BR = 5,
                   K_ADDI = 6, K_ADDS = 7, K_SUBS = 8, K_LDUR = 9, K_STUR = 10;

    logic           clk = 1'b0;
    logic           reset_n, id_valid, cbz_zero;
    logic [10:0]    id_opcode;
    logic [3:0]     id_cond, ex_flags_in;
    logic [RAW-1:0] id_rn, id_rm, id_rd;

    logic stall, flush_if, id_reg2loc, id_br_taken, id_uncond_br, id_br_reg;
    logic ex_valid, ex_set_flags, mem_valid, mem_write, mem_read;
    logic wb_valid, wb_regwrite, wb_memtoreg, wb_bl;
    logic [2:0] ex_aluop;
    logic [1:0] ex_alusrc;
    logic [RAW-1:0] wb_rd;
    logic [3:0] flags_q;

    logic stall2, flush2, r2l2, taken2, unc2, brreg2, exv2, exsf2, memv2, memw2, memr2;
    logic wbv2, wbrw2, wbm2, wbbl2;
    logic [2:0] aluop2;
    logic [1:0] alusrc2;
    logic [RAW-1:0] wbrd2;
    logic [3:0] flags2;

    always #5 clk = ~clk;

    pipe_control #(.OPW(11), .RAW(RAW), .FULL_COND(1), .FLAG_BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_cond(id_cond), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .cbz_zero(cbz_zero), .ex_flags_in(ex_flags_in), .stall(stall), .flush_if(flush_if),
        .id_reg2loc(id_reg2loc), .id_br_taken(id_br_taken), .id_uncond_br(id_uncond_br),
        .id_br_reg(id_br_reg), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
        .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .mem_valid(mem_valid),
        .mem_write(mem_write), .mem_read(mem_read), .wb_valid(wb_valid),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_bl(wb_bl),
        .wb_rd(wb_rd), .flags_q(flags_q));

    pipe_control #(.OPW(11), .RAW(RAW), .FULL_COND(0), .FLAG_BYPASS(0)) dut_lite (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_cond(id_cond), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .cbz_zero(cbz_zero), .ex_flags_in(ex_flags_in), .stall(stall2), .flush_if(flush2),
        .id_reg2loc(r2l2), .id_br_taken(taken2), .id_uncond_br(unc2),
        .id_br_reg(brreg2), .ex_valid(exv2), .ex_set_flags(exsf2),
        .ex_aluop(aluop2), .ex_alusrc(alusrc2), .mem_valid(memv2),
        .mem_write(memw2), .mem_read(memr2), .wb_valid(wbv2),
        .wb_regwrite(wbrw2), .wb_memtoreg(wbm2), .wb_bl(wbbl2),
        .wb_rd(wbrd2), .flags_q(flags2));

    typedef struct {
        bit v;
        int kind;
        int rd;
    } rec_t;

    int   nvec = 0;
    int   nfail = 0;
    rec_t ex_r, mem_r, wb_r;
    logic [3:0] m_flags;
    bit   exp_stall, exp_taken;

    function automatic int aluop_of(int k);
        if (k == K_ADDI || k == K_ADDS || k == K_LDUR || k == K_STUR) return 2;
        if (k == K_SUBS) return 3;
        return 0;
    endfunction

    function automatic int alusrc_of(int k);
        if (k == K_LDUR || k == K_STUR) return 1;
        if (k == K_ADDI) return 2;
        return 0;
    endfunction

    function automatic bit writes_reg(int k);
        return k == K_ADDI || k == K_ADDS || k == K_SUBS || k == K_LDUR || k == K_BL;
    endfunction

    function automatic bit sets_flags(int k);
        return k == K_ADDS || k == K_SUBS;
    endfunction

    function automatic int dest_of(int k, int rd);
        if (k == K_BL) return 30;
        return writes_reg(k) ? rd : 0;
    endfunction

    // Conditions come in true/inverted pairs; 14 and 15 are both "always".
    function automatic bit cond_true(int c, logic [3:0] f, bit full);
        bit n, z, cc, vv, base;
        n = f[3]; z = f[2]; cc = f[1]; vv = f[0];
        if (!full) return (c == 11) && (n != vv);
        case (c / 2)
            0: base = z;
            1: base = cc;
            2: base = n;
            3: base = vv;
            4: base = cc && !z;
            5: base = (n == vv);
            6: base = (n == vv) && !z;
            default: base = 1'b1;
        endcase
        return ((c % 2) == 1 && c < 14) ? !base : base;
    endfunction

    function automatic bit branch_taken(int k, int c, bit cz, logic [3:0] f, bit full);
        if (k == K_B || k == K_BL || k == K_BR) return 1'b1;
        if (k == K_BCOND) return cond_true(c, f, full);
        if (k == K_CBZ) return cz;
        return 1'b0;
    endfunction

    function automatic logic [10:0] opcode_of(int k);
        logic [10:0] r;
        logic [10:0] unk [4];
        r = 11'($urandom);
        unk[0] = 11'h000; unk[1] = 11'h7FF; unk[2] = 11'h001; unk[3] = 11'h555;
        case (k)
            K_B:     return {6'b000101, r[4:0]};
            K_BCOND: return {8'b01010100, r[2:0]};
            K_CBZ:   return {8'b10110100, r[2:0]};
            K_BL:    return {6'b100101, r[4:0]};
            K_BR:    return 11'b11010110000;
            K_ADDI:  return {10'b1001000100, r[0]};
            K_ADDS:  return 11'b10101011000;
            K_SUBS:  return 11'b11101011000;
            K_LDUR:  return 11'b11111000010;
            K_STUR:  return 11'b11111000000;
            default: return unk[r[1:0]];
        endcase
    endfunction

    function automatic int pick_reg();
        int regs [5];
        regs[0] = 1; regs[1] = 2; regs[2] = 3; regs[3] = 30; regs[4] = 31;
        return regs[$urandom_range(0, 4)];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, compare mid-cycle, advance the model at posedge.
    task automatic apply_stimulus(input bit rst, input bit v, input int k, input int rn,
                                  input int rm, input int rd, input int cnd, input bit cz,
                                  input logic [3:0] fl);
        bit lu, bh, go, t_full, t_lite;
        int src;
        logic [3:0] fsrc;
        @(negedge clk);
        reset_n = !rst; id_valid = v; id_opcode = opcode_of(k);
        id_rn = 5'(rn); id_rm = 5'(rm); id_rd = 5'(rd);
        id_cond = 4'(cnd); cbz_zero = cz; ex_flags_in = fl;
        if (rst) begin
            ex_r = '{0, K_NOP, 0}; mem_r = '{0, K_NOP, 0}; wb_r = '{0, K_NOP, 0};
            m_flags = 4'b0000;
        end
        lu = 1'b0;
        if (v && ex_r.v && ex_r.kind == K_LDUR && ex_r.rd != XZR) begin
            if (k == K_ADDI) lu = (ex_r.rd == rn);
            else if (k == K_ADDS || k == K_SUBS) lu = (ex_r.rd == rn) || (ex_r.rd == rm);
            else if (k == K_STUR) lu = (ex_r.rd == rn) || (ex_r.rd == rd);
        end
        bh = 1'b0;
        if (v && (k == K_CBZ || k == K_BR)) begin
            src = (k == K_CBZ) ? rd : rn;
            if (ex_r.v && writes_reg(ex_r.kind) && ex_r.rd != XZR && ex_r.rd == src) bh = 1'b1;
            if (mem_r.v && mem_r.kind == K_LDUR && mem_r.rd != XZR && mem_r.rd == src) bh = 1'b1;
        end
        exp_stall = lu || bh;
        go = v && !exp_stall;
        fsrc = (ex_r.v && sets_flags(ex_r.kind)) ? fl : m_flags;
        t_full = go && branch_taken(k, cnd, cz, fsrc, 1'b1);
        t_lite = go && branch_taken(k, cnd, cz, m_flags, 1'b0);
        exp_taken = t_full;
        #2;
        check_output("stall", stall, exp_stall);
        check_output("flush_if", flush_if, t_full);
        check_output("id_br_taken", id_br_taken, t_full);
        check_output("id_reg2loc", id_reg2loc, go && (k == K_CBZ || k == K_STUR));
        check_output("id_uncond_br", id_uncond_br, go && (k == K_B || k == K_BL || k == K_BR));
        check_output("id_br_reg", id_br_reg, go && k == K_BR);
        check_output("ex_valid", ex_valid, ex_r.v);
        check_output("ex_set_flags", ex_set_flags, sets_flags(ex_r.kind));
        check_output("ex_aluop", ex_aluop, aluop_of(ex_r.kind));
        check_output("ex_alusrc", ex_alusrc, alusrc_of(ex_r.kind));
        check_output("mem_valid", mem_valid, mem_r.v);
        check_output("mem_write", mem_write, mem_r.kind == K_STUR);
        check_output("mem_read", mem_read, mem_r.kind == K_LDUR);
        check_output("wb_valid", wb_valid, wb_r.v);
        check_output("wb_regwrite", wb_regwrite, writes_reg(wb_r.kind));
        check_output("wb_memtoreg", wb_memtoreg, wb_r.kind == K_LDUR);
        check_output("wb_bl", wb_bl, wb_r.kind == K_BL);
        check_output("wb_rd", wb_rd, wb_r.rd);
        check_output("flags_q", flags_q, m_flags);
        check_output("lite_stall", stall2, exp_stall);
        check_output("lite_br_taken", taken2, t_lite);
        check_output("lite_flags_q", flags2, m_flags);
        @(posedge clk);
        if (!rst) begin
            if (ex_r.v && sets_flags(ex_r.kind)) m_flags = fl;
            wb_r  = mem_r;
            mem_r = ex_r;
            ex_r  = (go && k != K_NOP) ? '{1, k, dest_of(k, rd)} : '{0, K_NOP, 0};
        end
    endtask

    // Re-presents a held instruction while the model expects a stall (bounded).
    task automatic issue(input int k, input int rn, input int rm, input int rd,
                         input int cnd, input bit cz, input logic [3:0] fl);
        apply_stimulus(0, 1, k, rn, rm, rd, cnd, cz, fl);
        for (int i = 0; i < 3 && exp_stall; i++)
            apply_stimulus(0, 1, k, rn, rm, rd, cnd, cz, fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(0, 0, K_NOP, 0, 0, 0, 0, 0, 4'($urandom));
    endtask

    initial begin
        int k, rn, rm, rd, cnd;
        bit v, cz;
        reset_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_cond = '0;
        id_rn = '0; id_rm = '0; id_rd = '0; cbz_zero = 1'b0; ex_flags_in = '0;
        ex_r = '{0, K_NOP, 0}; mem_r = '{0, K_NOP, 0}; wb_r = '{0, K_NOP, 0};
        m_flags = 4'b0000;

        apply_stimulus(1, 1, K_ADDS, 1, 2, 3, 0, 0, 4'hF);
        apply_stimulus(1, 1, K_ADDS, 1, 2, 3, 0, 0, 4'hF);
        issue(K_ADDS, 1, 2, 3, 0, 0, 4'h0);
        idle(4);

        issue(K_LDUR, 5, 0, 1, 0, 0, 4'h0);
        issue(K_ADDS, 1, 3, 2, 0, 0, 4'h0);
        idle(4);

        issue(K_LDUR, 5, 0, 4, 0, 0, 4'h0);
        issue(K_CBZ, 0, 0, 4, 0, 1, 4'h0);
        idle(3);

        issue(K_ADDI, 7, 0, 6, 0, 0, 4'h0);
        issue(K_CBZ, 0, 0, 6, 0, 1, 4'h0);
        issue(K_LDUR, 5, 0, 31, 0, 0, 4'h0);
        issue(K_ADDS, 31, 31, 2, 0, 0, 4'h0);
        issue(K_STUR, 4, 0, 3, 0, 0, 4'h0);
        idle(3);

        apply_stimulus(0, 1, K_LDUR, 5, 0, 1, 0, 0, 4'h0);
        apply_stimulus(0, 1, K_ADDS, 1, 2, 3, 0, 0, 4'h0);
        apply_stimulus(1, 1, K_ADDS, 1, 2, 3, 0, 0, 4'h0);
        apply_stimulus(0, 1, K_ADDS, 1, 2, 3, 0, 0, 4'h0);
        idle(3);

        apply_stimulus(1, 0, K_NOP, 0, 0, 0, 0, 0, 4'h0);
        issue(K_SUBS, 1, 2, 3, 0, 0, 4'h0);
        issue(K_BCOND, 0, 0, 0, 11, 0, 4'b1000);
        idle(3);

        issue(K_SUBS, 1, 2, 3, 0, 0, 4'h0);
        apply_stimulus(0, 0, K_NOP, 0, 0, 0, 0, 0, 4'b0110);
        for (int c = 0; c < 16; c++)
            issue(K_BCOND, 0, 0, 0, c, 0, 4'($urandom));

        issue(K_BL, 0, 0, 9, 0, 0, 4'h0);
        issue(K_BR, 30, 0, 0, 0, 0, 4'h0);
        idle(3);
        issue(K_NOP, 1, 1, 1, 0, 1, 4'h0);
        issue(K_B, 0, 0, 0, 0, 0, 4'h0);
        idle(3);

        k = K_NOP; rn = 0; rm = 0; rd = 0; cnd = 0; cz = 0; v = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                apply_stimulus(1, 1, k, rn, rm, rd, cnd, cz, 4'($urandom));
                continue;
            end
            if (!exp_stall) begin
                if (exp_taken) begin
                    v = 0;
                end else begin
                    v = ($urandom_range(0, 9) != 0);
                    k = $urandom_range(0, 10);
                    rn = pick_reg(); rm = pick_reg(); rd = pick_reg();
                    cnd = $urandom_range(0, 15);
                    cz = 1'($urandom);
                end
            end
            apply_stimulus(0, v, k, rn, rm, rd, cnd, cz, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
